phase_sequencer: RTL and testbench
==================================

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable cycles needed before the debounced button level changes.
REQ-002 Parameter PULSE_CYCLES, default 4: high width of each phase strobe, and also the low gap after each strobe.
REQ-003 Parameter AUTO_PERIOD, default 50000000: clk cycles between auto-step ticks.
REQ-004 clk  input  1  single system clock; all logic rising-edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 step_btn  input  1  raw, bouncy, asynchronous single-step button.
REQ-007 auto_en  input  1  1 = self-stepping every AUTO_PERIOD cycles.
REQ-008 wr_req  input  1  requested register write-enable for the next instruction.
REQ-009 clk_RR  output  1  register-read phase strobe.
REQ-010 clk_F  output  1  ALU/flag phase strobe.
REQ-011 clk_WB  output  1  write-back phase strobe.
REQ-012 Reg_Write  output  1  write-enable held stable for the whole sequence.
REQ-013 phase  output  2  0 idle, 1 RR, 2 F, 3 WB.
REQ-014 busy  output  1  sequence in progress.
REQ-015 instr_cnt  output  16  count of completed sequences.

Function
REQ-016 step_btn SHALL pass a 2-FF synchronizer; the debounced level SHALL take the synchronized value only after DEBOUNCE_CYCLES consecutive equal samples.
REQ-017 A trigger SHALL be one cycle on a debounced 0->1 transition, or one cycle on an auto tick.
REQ-018 Auto counter SHALL be held at 0 while auto_en=0; while auto_en=1 it SHALL tick every AUTO_PERIOD cycles, the first tick AUTO_PERIOD cycles after auto_en rises.
REQ-019 A button trigger and an auto tick in the same cycle SHALL start exactly one sequence.
REQ-020 Triggers arriving while busy=1 SHALL be dropped, not queued.
REQ-021 FSM states: IDLE, RR, F, WB. Each active state holds its strobe high for PULSE_CYCLES, then low for PULSE_CYCLES.
REQ-022 FSM transitions: RR->F and F->WB after each state's 2*PULSE_CYCLES; WB->IDLE after its 2*PULSE_CYCLES.
REQ-023 Timing from a trigger in cycle T, with P = PULSE_CYCLES:
  - clk_RR high in cycles T+1..T+P
  - clk_F high in cycles T+2P+1..T+3P
  - clk_WB high in cycles T+4P+1..T+5P
  - busy high in cycles T+1..T+6P
REQ-024 At most one strobe SHALL be high in any cycle; all strobes SHALL be registered outputs (glitch-free).
REQ-025 Reg_Write SHALL latch wr_req in trigger cycle T, hold it for cycles T+1..T+6P, and read 0 whenever IDLE.
REQ-026 phase SHALL equal the current state encoding.
REQ-027 instr_cnt SHALL increment by 1 in the cycle IDLE is re-entered (T+6P+1) and wrap from 0xFFFF to 0x0000.
REQ-028 A change of auto_en mid-sequence SHALL NOT affect the running sequence.

Reset
REQ-029 rst=1 SHALL immediately force these to 0: strobes, Reg_Write, busy, phase, instr_cnt, debounced level, and all counters; FSM goes to IDLE.
REQ-030 Reset mid-sequence SHALL abort the sequence with no further strobes after reset release until a new trigger.
REQ-031 If step_btn is held through reset release, exactly one trigger SHALL occur, DEBOUNCE_CYCLES (+sync delay) after release.

Verification (DEBOUNCE_CYCLES=4, PULSE_CYCLES=2, AUTO_PERIOD=20)
REQ-032 Clean press, wr_req=1:
  - clk_RR high T+1..T+2, clk_F high T+5..T+6, clk_WB high T+9..T+10
  - Reg_Write=1 and busy=1 for T+1..T+12
  - instr_cnt 0->1 at T+13
REQ-033 Bounce: step_btn toggles every 2 cycles for 20 cycles, then stays high -> exactly one sequence; toggle-only burst -> none.
REQ-034 Second press debounced during busy -> dropped; instr_cnt advances by 1 only.
REQ-035 auto_en=1 for 100 cycles, no button -> 5 sequences, instr_cnt=5, with strobe order RR,F,WB each time.
REQ-036 rst pulsed in cycle T+6 (clk_F high):
  - all outputs 0 at once
  - no clk_WB follows
  - instr_cnt=0
REQ-037 Preload by running 65536 sequences -> instr_cnt wraps to 0x0000.

Source files
------------

// File: rtl/phase_sequencer.sv
// Three-phase strobe sequencer (RR -> F -> WB) started by a debounced step button or an auto-step timer.
// Each active phase holds its strobe high for PULSE_CYCLES and then low for PULSE_CYCLES.
module phase_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int PULSE_CYCLES    = 4,
    parameter int AUTO_PERIOD     = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step_btn,
    input  logic        auto_en,
    input  logic        wr_req,
    output logic        clk_RR,
    output logic        clk_F,
    output logic        clk_WB,
    output logic        Reg_Write,
    output logic [1:0]  phase,
    output logic        busy,
    output logic [15:0] instr_cnt
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int AUTO_W = $clog2(AUTO_PERIOD + 1);
    localparam int PH_W   = $clog2(2 * PULSE_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_PERIOD - 1);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(2 * PULSE_CYCLES - 1);
    localparam logic [PH_W-1:0]   PULSE_LIM = PH_W'(PULSE_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RR   = 2'd1,
        ST_F    = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    state_t            state, next_state;
    logic [PH_W-1:0]   ph_cnt, next_cnt;
    logic              next_rr, next_f, next_wb, next_wr, strobe_on;
    logic [15:0]       next_instr;

    logic              sync_meta, sync_btn;
    logic              db_level, db_prev;
    logic [DB_W-1:0]   db_cnt;
    logic [AUTO_W-1:0] auto_cnt;
    logic              auto_tick;
    logic              btn_trig, trigger;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= 1'b0;
            sync_btn  <= 1'b0;
        end else begin
            sync_meta <= step_btn;
            sync_btn  <= sync_meta;
        end
    end

    // The level only flips once the synchronized input has disagreed with it for DEBOUNCE_CYCLES samples in a row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_level <= 1'b0;
            db_prev  <= 1'b0;
            db_cnt   <= '0;
        end else begin
            db_prev <= db_level;
            if (sync_btn == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_level <= sync_btn;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            auto_cnt  <= '0;
            auto_tick <= 1'b0;
        end else if (!auto_en) begin
            auto_cnt  <= '0;
            auto_tick <= 1'b0;
        end else begin
            auto_tick <= (auto_cnt == AUTO_LAST);
            auto_cnt  <= (auto_cnt == AUTO_LAST) ? '0 : auto_cnt + 1'b1;
        end
    end

    assign btn_trig = db_level & ~db_prev;
    assign trigger  = btn_trig | auto_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            ph_cnt    <= '0;
            clk_RR    <= 1'b0;
            clk_F     <= 1'b0;
            clk_WB    <= 1'b0;
            Reg_Write <= 1'b0;
            instr_cnt <= '0;
        end else begin
            state     <= next_state;
            ph_cnt    <= next_cnt;
            clk_RR    <= next_rr;
            clk_F     <= next_f;
            clk_WB    <= next_wb;
            Reg_Write <= next_wr;
            instr_cnt <= next_instr;
        end
    end

    // Strobes are decoded from the next state so they leave the register stage clean.
    always_comb begin
        next_state = state;
        next_cnt   = ph_cnt;
        next_wr    = Reg_Write;
        next_instr = instr_cnt;
        case (state)
            ST_IDLE: begin
                if (trigger) begin
                    next_state = ST_RR;
                    next_cnt   = '0;
                    next_wr    = wr_req;
                end
            end
            default: begin
                if (ph_cnt == PH_LAST) begin
                    next_cnt = '0;
                    case (state)
                        ST_RR:   next_state = ST_F;
                        ST_F:    next_state = ST_WB;
                        default: begin
                            next_state = ST_IDLE;
                            next_wr    = 1'b0;
                            next_instr = instr_cnt + 16'd1;
                        end
                    endcase
                end else begin
                    next_cnt = ph_cnt + 1'b1;
                end
            end
        endcase
        strobe_on = (next_state != ST_IDLE) && (next_cnt < PULSE_LIM);
        next_rr   = strobe_on && (next_state == ST_RR);
        next_f    = strobe_on && (next_state == ST_F);
        next_wb   = strobe_on && (next_state == ST_WB);
    end

    assign phase = state;
    assign busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer with DEBOUNCE_CYCLES=4, PULSE_CYCLES=2, AUTO_PERIOD=20.
// A button press applied before edge e0 produces a trigger after e5, so sequence timing is checked with t=5.
module tb_phase_sequencer;

    localparam int P = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        step_btn = 1'b0;
    logic        auto_en = 1'b0;
    logic        wr_req = 1'b0;
    logic        clk_RR, clk_F, clk_WB, Reg_Write, busy;
    logic [1:0]  phase;
    logic [15:0] instr_cnt;

    int vectors = 0;
    int miscompares = 0;

    int   rr_rises = 0, f_rises = 0, wb_rises = 0;
    int   order_err = 0, overlap_err = 0, last_strobe = 0;
    logic prev_rr = 1'b0, prev_f = 1'b0, prev_wb = 1'b0;

    phase_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .PULSE_CYCLES(P),
        .AUTO_PERIOD(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .step_btn(step_btn),
        .auto_en(auto_en),
        .wr_req(wr_req),
        .clk_RR(clk_RR),
        .clk_F(clk_F),
        .clk_WB(clk_WB),
        .Reg_Write(Reg_Write),
        .phase(phase),
        .busy(busy),
        .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    // Strobe watcher: counts rising strobes, flags overlap and any order other than RR, F, WB.
    always @(negedge clk) begin
        if (rst) begin
            last_strobe = 0;
        end else begin
            if (int'(clk_RR) + int'(clk_F) + int'(clk_WB) > 1) overlap_err++;
            if (clk_RR && !prev_rr) begin
                rr_rises++;
                if (last_strobe == 1 || last_strobe == 2) order_err++;
                last_strobe = 1;
            end
            if (clk_F && !prev_f) begin
                f_rises++;
                if (last_strobe != 1) order_err++;
                last_strobe = 2;
            end
            if (clk_WB && !prev_wb) begin
                wb_rises++;
                if (last_strobe != 2) order_err++;
                last_strobe = 3;
            end
        end
        prev_rr = clk_RR;
        prev_f  = clk_F;
        prev_wb = clk_WB;
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic btn, input logic auto, input logic wr);
        step_btn = btn;
        auto_en  = auto;
        wr_req   = wr;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic checkIdle(input string name);
        checkOutput({name, "_rr"}, clk_RR, 1'b0);
        checkOutput({name, "_f"}, clk_F, 1'b0);
        checkOutput({name, "_wb"}, clk_WB, 1'b0);
        checkOutput({name, "_regwrite"}, Reg_Write, 1'b0);
        checkOutput({name, "_busy"}, busy, 1'b0);
        checkOutput({name, "_phase"}, phase, 2'd0);
        checkOutput({name, "_cnt"}, instr_cnt, 16'd0);
    endtask

    // Expected outputs k cycles after e0 for a sequence triggered in cycle t.
    task automatic checkSeqCycle(input string name, input int k, input int t, input logic wr, input logic [15:0] base);
        logic       e_rr, e_f, e_wb, e_busy;
        logic [1:0] e_phase;
        e_rr    = (k >= t + 1) && (k <= t + P);
        e_f     = (k >= t + 2*P + 1) && (k <= t + 3*P);
        e_wb    = (k >= t + 4*P + 1) && (k <= t + 5*P);
        e_busy  = (k >= t + 1) && (k <= t + 6*P);
        e_phase = !e_busy ? 2'd0 : (k <= t + 2*P) ? 2'd1 : (k <= t + 4*P) ? 2'd2 : 2'd3;
        checkOutput($sformatf("%s_rr_k%0d", name, k), clk_RR, e_rr);
        checkOutput($sformatf("%s_f_k%0d", name, k), clk_F, e_f);
        checkOutput($sformatf("%s_wb_k%0d", name, k), clk_WB, e_wb);
        checkOutput($sformatf("%s_busy_k%0d", name, k), busy, e_busy);
        checkOutput($sformatf("%s_phase_k%0d", name, k), phase, e_phase);
        checkOutput($sformatf("%s_regwrite_k%0d", name, k), Reg_Write, e_busy && wr);
        checkOutput($sformatf("%s_cnt_k%0d", name, k), instr_cnt,
                    (k >= t + 6*P + 1) ? 16'(base + 16'd1) : base);
    endtask

    initial begin
        int rr0, wb0;

        applyStimulus(1'b0, 1'b0, 1'b0);
        waitCycles(2);
        checkIdle("reset");
        rst = 1'b0;
        waitCycles(2);

        // Clean press with wr_req=1; wr_req drops mid-sequence and Reg_Write must hold.
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 25; k++) begin
            tick();
            if (k == 8) wr_req = 1'b0;
            checkSeqCycle("press_wr1", k, 5, 1'b1, 16'd0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitCycles(10);

        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 25; k++) begin
            tick();
            checkSeqCycle("press_wr0", k, 5, 1'b0, 16'd1);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitCycles(10);

        // Bounce ending high: exactly one sequence.
        rr0 = rr_rises;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(((i / 2) % 2) == 0, 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCycles(30);
        checkOutput("bounce_rr_count", 16'(rr_rises - rr0), 16'd1);
        checkOutput("bounce_cnt", instr_cnt, 16'd3);
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitCycles(10);

        // Toggle-only burst: nothing starts.
        rr0 = rr_rises;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(((i / 2) % 2) == 0, 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitCycles(20);
        checkOutput("toggle_rr_count", 16'(rr_rises - rr0), 16'd0);
        checkOutput("toggle_cnt", instr_cnt, 16'd3);

        // Short press, then a second press that debounces high during WB: it must be dropped.
        rr0 = rr_rises;
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 31; k++) begin
            tick();
            if (k == 5) step_btn = 1'b0;
            if (k == 11) step_btn = 1'b1;
            checkSeqCycle("drop", k, 5, 1'b1, 16'd3);
        end
        checkOutput("drop_rr_count", 16'(rr_rises - rr0), 16'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitCycles(10);

        rst = 1'b1;
        tick();
        checkIdle("reset2");
        rst = 1'b0;
        waitCycles(2);

        // Auto-stepping for 100 cycles: ticks after e19, e39, e59, e79, e99.
        rr0 = rr_rises;
        wb0 = wb_rises;
        applyStimulus(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 100; k++) begin
            tick();
            if (k == 19) checkOutput("auto_first_idle", busy, 1'b0);
            if (k == 20) checkOutput("auto_first_rr", clk_RR, 1'b1);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitCycles(30);
        checkOutput("auto_rr_count", 16'(rr_rises - rr0), 16'd5);
        checkOutput("auto_wb_count", 16'(wb_rises - wb0), 16'd5);
        checkOutput("auto_cnt", instr_cnt, 16'd5);

        // Reset while clk_F is high aborts the sequence immediately.
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 12; k++) begin
            tick();
            if (k == 5) step_btn = 1'b0;
            checkSeqCycle("abort", k, 5, 1'b1, 16'd5);
        end
        #1 rst = 1'b1;
        #1 checkIdle("abort_async");
        tick();
        rst = 1'b0;
        rr0 = rr_rises;
        wb0 = wb_rises;
        waitCycles(30);
        checkOutput("abort_wb_count", 16'(wb_rises - wb0), 16'd0);
        checkOutput("abort_rr_count", 16'(rr_rises - rr0), 16'd0);
        checkOutput("abort_cnt", instr_cnt, 16'd0);
        checkOutput("abort_busy", busy, 1'b0);

        // Button held through reset release gives exactly one sequence.
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCycles(3);
        rst = 1'b1;
        waitCycles(2);
        rst = 1'b0;
        rr0 = rr_rises;
        for (int k = 0; k < 25; k++) begin
            tick();
            checkSeqCycle("held", k, 5, 1'b0, 16'd0);
        end
        waitCycles(15);
        checkOutput("held_rr_count", 16'(rr_rises - rr0), 16'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitCycles(10);

        // Start the counter at its top value so the next completion wraps.
        force dut.instr_cnt = 16'hFFFF;
        tick();
        release dut.instr_cnt;
        tick();
        checkOutput("wrap_preload", instr_cnt, 16'hFFFF);
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 25; k++) begin
            tick();
            checkSeqCycle("wrap", k, 5, 1'b0, 16'hFFFF);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitCycles(5);

        checkOutput("strobe_order", 16'(order_err), 16'd0);
        checkOutput("strobe_overlap", 16'(overlap_err), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
